conf_bus_master: RTL and testbench

Configuration-bus initiator for the global controller. Accepts (target select, data) commands into a small FIFO and presents each one on the shared `sel`/`conf_bus` configuration bus. It waits for the addressed target's sticky `conf_ack`, then retires the command. Completion, timeout and protocol errors are reported to the host/configuration sequencer. The clock generator (select ID 1) and the other configurable controller blocks are the targets.

---
 rtl/conf_bus_master.sv | 177 +++++++++++++++++
 tb/tb_conf_bus_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : conf_bus_master
//  Purpose  : Configuration-bus initiator. It queues (select, data) commands,
//             issues each one on sel/conf_bus and retires it on the target ack.
//  Revision : 1.0
// ============================================================================
module conf_bus_master #(
    parameter int DATA_WIDTH   = 8,
    parameter int SELECT_WIDTH = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                          conf_clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [SELECT_WIDTH-1:0]       cmd_sel,
    input  logic [DATA_WIDTH-1:0]         cmd_data,
    output logic                          cmd_ready,
    input  logic                          err_clr,
    input  logic [(2**SELECT_WIDTH)-1:0]  ack_in,
    output logic [SELECT_WIDTH-1:0]       sel,
    output logic [DATA_WIDTH-1:0]         conf_bus,
    output logic                          done,
    output logic                          err_timeout,
    output logic                          err_stale,
    output logic                          err_sel0,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = SELECT_WIDTH + DATA_WIDTH;
    localparam logic [AW:0]  c_FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]  c_TMO_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    logic [EW-1:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count_q, count_d;
    logic [1:0]              state_q, state_d;
    logic [15:0]             timer_q, timer_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   bus_q, bus_d;
    logic                    done_q, done_d;
    logic                    to_q, to_d, st_q, st_d, s0_q, s0_d;
    logic                    set_to, set_st, set_s0;
    logic                    w_push, w_pop;
    logic [SELECT_WIDTH-1:0] w_head_sel;
    logic [DATA_WIDTH-1:0]   w_head_data;

    assign cmd_ready   = (count_q != c_FULL);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_head_sel  = mem_q[rd_ptr_q][EW-1:DATA_WIDTH];
    assign w_head_data = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge conf_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cmd_sel, cmd_data};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        bus_d   = bus_q;
        done_d  = 1'b0;
        w_pop   = 1'b0;
        set_to  = 1'b0;
        set_st  = 1'b0;
        set_s0  = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (count_q != '0) begin
                    w_pop = 1'b1;
                    if (w_head_sel == '0) begin
                        set_s0 = 1'b1;
                    end else begin
                        sel_d   = w_head_sel;
                        bus_d   = w_head_data;
                        state_d = c_ISSUE;
                    end
                end
            end
            c_ISSUE: begin
                // An ack already high means the target never saw this command.
                if (ack_in[sel_q]) begin
                    set_st  = 1'b1;
                    sel_d   = '0;
                    bus_d   = '0;
                    state_d = c_IDLE;
                end else begin
                    timer_d = '0;
                    state_d = c_WAIT;
                end
            end
            c_WAIT: begin
                if (ack_in[sel_q]) begin
                    done_d  = 1'b1;
                    sel_d   = '0;
                    bus_d   = '0;
                    state_d = c_IDLE;
                end else if (timer_q == c_TMO_LAST) begin
                    set_to  = 1'b1;
                    sel_d   = '0;
                    bus_d   = '0;
                    state_d = c_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                sel_d   = '0;
                bus_d   = '0;
                state_d = c_IDLE;
            end
        endcase
    end

    // A new error event on the clear edge takes precedence over the clear.
    assign to_d = (to_q & ~err_clr) | set_to;
    assign st_d = (st_q & ~err_clr) | set_st;
    assign s0_d = (s0_q & ~err_clr) | set_s0;

    always_ff @(posedge conf_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= c_IDLE;
            timer_q  <= '0;
            sel_q    <= '0;
            bus_q    <= '0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            st_q     <= 1'b0;
            s0_q     <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            bus_q   <= bus_d;
            done_q  <= done_d;
            to_q    <= to_d;
            st_q    <= st_d;
            s0_q    <= s0_d;
        end
    end

    assign sel         = sel_q;
    assign conf_bus    = bus_q;
    assign done        = done_q;
    assign err_timeout = to_q;
    assign err_stale   = st_q;
    assign err_sel0    = s0_q;
    assign busy        = (state_q != c_IDLE) || (count_q != '0);
    assign fifo_level  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_conf_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conf_bus_master
//  Purpose  : Self-checking bench for conf_bus_master with behavioural targets.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_conf_bus_master;

    localparam int DW = 8;
    localparam int SW = 3;
    localparam int FD = 4;
    localparam int TO = 16;

    logic          conf_clk = 1'b0;
    logic          reset    = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [SW-1:0] cmd_sel   = '0;
    logic [DW-1:0] cmd_data  = '0;
    logic          cmd_ready;
    logic          err_clr   = 1'b0;
    logic [7:0]    ack_in;
    logic [SW-1:0] sel;
    logic [DW-1:0] conf_bus;
    logic          done, err_timeout, err_stale, err_sel0, busy;
    logic [2:0]    fifo_level;

    conf_bus_master #(
        .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .FIFO_DEPTH(FD), .TIMEOUT(TO)
    ) dut (
        .conf_clk(conf_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .err_clr(err_clr), .ack_in(ack_in),
        .sel(sel), .conf_bus(conf_bus), .done(done),
        .err_timeout(err_timeout), .err_stale(err_stale), .err_sel0(err_sel0),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 conf_clk = ~conf_clk;

    // Targets: each enabled target acks one edge after it sees its select.
    logic [7:0] ack_en    = '0;
    logic [7:0] force_ack = '0;
    logic [7:0] ack_q;
    always @(posedge conf_clk or posedge reset) begin
        if (reset) ack_q <= '0;
        else       ack_q <= ack_en & (8'b1 << sel);
    end
    assign ack_in = ack_q | force_ack;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int bus_cycles = 0;
    bit seen09 = 0;
    int done_times[$];
    logic [SW+DW-1:0] exp_q[$];
    logic [SW-1:0] prev_sel = '0;
    logic [DW-1:0] prev_bus = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge conf_clk) cyc++;

    // Bus monitor: scoreboard compare at every new issue, stability while held.
    always @(negedge conf_clk) begin
        if (done) begin
            done_cnt++;
            done_times.push_back(cyc);
        end
        if (sel != '0) bus_cycles++;
        if (conf_bus == 8'h09) seen09 = 1;
        if (sel != '0 && prev_sel == '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL issue: unexpected sel=%0d data=%0h", sel, conf_bus);
            end else begin
                logic [SW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({sel, conf_bus} !== e) begin
                    fails++;
                    $display("FAIL issue: got sel=%0d data=%0h, expected sel=%0d data=%0h",
                             sel, conf_bus, e[SW+DW-1:DW], e[DW-1:0]);
                end
            end
        end else if (sel != '0 && (sel != prev_sel || conf_bus != prev_bus)) begin
            fails++;
            $display("FAIL bus_stable: got sel=%0d data=%0h, expected sel=%0d data=%0h",
                     sel, conf_bus, prev_sel, prev_bus);
        end
        prev_sel = sel;
        prev_bus = conf_bus;
    end

    task automatic step(input int n);
        repeat (n) @(negedge conf_clk);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] s, input logic [DW-1:0] d, input logic acc);
        check("cmd_ready", cmd_ready, acc);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_data  = d;
        step(1);
        cmd_valid = 1'b0;
        if (acc && s != '0) exp_q.push_back({s, d});
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        check("idle_within_budget", busy, 1'b0);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr", {err_timeout, err_stale, err_sel0}, 3'b000);
    endtask

    typedef struct {
        logic [SW-1:0] s;
        logic [DW-1:0] d;
        logic          ack;
        int            exp_done;
        logic          exp_to;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int d0, bc0;
        tbl[0] = '{3'd1, 8'h03, 1'b1, 1, 1'b0};
        tbl[1] = '{3'd2, 8'hA5, 1'b1, 1, 1'b0};
        tbl[2] = '{3'd7, 8'hFF, 1'b1, 1, 1'b0};
        tbl[3] = '{3'd3, 8'h00, 1'b0, 0, 1'b1};
        tbl[4] = '{3'd6, 8'h5A, 1'b1, 1, 1'b0};
        tbl[5] = '{3'd4, 8'hC3, 1'b0, 0, 1'b1};

        step(2);
        reset = 1'b0;
        step(1);
        check("rst_sel", sel, 0);
        check("rst_bus", conf_bus, 0);
        check("rst_done", done, 0);
        check("rst_errs", {err_timeout, err_stale, err_sel0}, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);

        // Single command with exact edge timing.
        ack_en = 8'b0000_0010;
        d0 = done_cnt;
        push(3'd1, 8'h03, 1'b1);
        check("single_level", fifo_level, 1);
        check("single_sel_pre", sel, 0);
        step(1);
        check("single_e1", {sel, conf_bus}, {3'd1, 8'h03});
        step(1);
        check("single_e2", {sel, conf_bus, done}, {3'd1, 8'h03, 1'b0});
        step(1);
        check("single_e3", {sel, conf_bus, done}, {3'd0, 8'h00, 1'b1});
        step(1);
        check("single_e4", {done, busy}, 2'b00);
        check("single_done_cnt", done_cnt - d0, 1);

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) begin
            ack_en = tbl[i].ack ? (8'b1 << tbl[i].s) : 8'h00;
            d0 = done_cnt;
            push(tbl[i].s, tbl[i].d, 1'b1);
            wait_idle(60);
            check("tbl_done", done_cnt - d0, tbl[i].exp_done);
            check("tbl_timeout", err_timeout, tbl[i].exp_to);
            clear_errs();
        end

        // Back-to-back, three cycles per command.
        ack_en = 8'b0000_1110;
        d0 = done_cnt;
        done_times.delete();
        push(3'd1, 8'h02, 1'b1);
        push(3'd2, 8'h05, 1'b1);
        push(3'd3, 8'h07, 1'b1);
        wait_idle(40);
        check("b2b_done", done_cnt - d0, 3);
        check("b2b_times", done_times.size(), 3);
        if (done_times.size() == 3) begin
            check("b2b_gap1", done_times[1] - done_times[0], 3);
            check("b2b_gap2", done_times[2] - done_times[1], 3);
        end

        // Timeout timing, then the next command proceeds.
        ack_en = 8'b0010_0000;
        d0 = done_cnt;
        push(3'd3, 8'h30, 1'b1);
        push(3'd5, 8'h50, 1'b1);
        step(16);
        check("to_before", {err_timeout, sel}, {1'b0, 3'd3});
        step(1);
        check("to_at", {err_timeout, sel}, {1'b1, 3'd0});
        wait_idle(40);
        check("to_next_done", done_cnt - d0, 1);
        clear_errs();

        // Full FIFO: head command stuck on a silent target.
        ack_en = 8'b1111_0000;
        d0 = done_cnt;
        push(3'd2, 8'h21, 1'b1);
        step(1);
        check("full_level0", fifo_level, 0);
        push(3'd4, 8'h41, 1'b1);
        push(3'd5, 8'h51, 1'b1);
        push(3'd6, 8'h61, 1'b1);
        push(3'd7, 8'h71, 1'b1);
        check("full_level4", fifo_level, 4);
        push(3'd3, 8'h31, 1'b0);
        check("full_dropped", fifo_level, 4);
        wait_idle(200);
        check("full_done", done_cnt - d0, 4);
        check("full_timeout", err_timeout, 1);
        check("full_sb_empty", exp_q.size(), 0);
        clear_errs();

        // Stale ack and select-0 command.
        ack_en = 8'h00;
        force_ack = 8'b0000_0010;
        d0 = done_cnt;
        bc0 = bus_cycles;
        seen09 = 0;
        push(3'd1, 8'h04, 1'b1);
        push(3'd0, 8'h09, 1'b1);
        step(4);
        check("stale_flag", err_stale, 1);
        check("sel0_flag", err_sel0, 1);
        check("stale_no_done", done_cnt - d0, 0);
        check("stale_bus_cycles", bus_cycles - bc0, 1);
        check("sel0_no_data", seen09, 0);
        check("stale_idle", busy, 0);
        force_ack = 8'h00;
        clear_errs();

        // Asynchronous reset while waiting with two commands queued.
        ack_en = 8'h00;
        push(3'd2, 8'h11, 1'b1);
        push(3'd3, 8'h22, 1'b1);
        push(3'd4, 8'h33, 1'b1);
        step(4);
        check("rstw_level", fifo_level, 2);
        check("rstw_sel", sel, 2);
        #2 reset = 1'b1;
        #1;
        check("rstw_out", {sel, conf_bus, done}, 0);
        check("rstw_errs", {err_timeout, err_stale, err_sel0}, 0);
        check("rstw_fifo", {fifo_level, busy, cmd_ready}, {3'd0, 1'b0, 1'b1});
        exp_q.delete();
        step(2);
        reset = 1'b0;
        bc0 = bus_cycles;
        step(10);
        check("rstw_quiet", bus_cycles - bc0, 0);
        check("rstw_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
